// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Mode encodings, the default pattern and the fill-counter width function.
package seq_det_pkg;

  localparam logic MODE_NOVL = 1'b0;
  localparam logic MODE_OVL  = 1'b1;

  localparam logic [3:0] SEQ_PAT_1010 = 4'b1010;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_det_prog_if.sv
// Serial-input bundle for seq_det_prog.
// match_cnt and CNT_W exist only when SEQ_DET_CNT_EN is defined.
interface seq_det_prog_if #(
  parameter int PAT_W = 4
`ifdef SEQ_DET_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
);

  logic             din;
  logic             din_vld;
  logic             ovl_mode;
  logic             pat_ld;
  logic [PAT_W-1:0] pat_in;
  logic             match;
  logic             busy;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  modport master (
    output din,
    output din_vld,
    output ovl_mode,
    output pat_ld,
    output pat_in,
    input  match,
    input  busy
`ifdef SEQ_DET_CNT_EN
    ,
    input  match_cnt
`endif
  );

  modport slave (
    input  din,
    input  din_vld,
    input  ovl_mode,
    input  pat_ld,
    input  pat_in,
    output match,
    output busy
`ifdef SEQ_DET_CNT_EN
    ,
    output match_cnt
`endif
  );

endinterface

// File: rtl/seq_sat_cnt.sv
// Saturating up-counter with synchronous reset and clear.
// Holds at all-ones once reached; clear beats increment.
module seq_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector, Mealy match, runtime overlap mode.
// Define SEQ_DET_CNT_EN to add the saturating match_cnt output.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(SEQ_PAT_1010),
  parameter int               CNT_W   = 8
) (
  input logic           clk,
  input logic           rst,
  seq_det_prog_if.slave bus
);

  localparam int FW = clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  if (PAT_W < 2 || PAT_W > 16 || CNT_W < 1) begin : g_bad_param
    $error("seq_det_prog: illegal PAT_W or CNT_W");
  end

  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] pat_d;
  logic [PAT_W-2:0] hist_q;
  logic [PAT_W-2:0] hist_d;
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_d;

  logic [PAT_W-1:0] win;
  logic             hit;
  logic             match_w;

  // Full window: stored history with the incoming bit appended as LSB.
  assign win = {hist_q, bus.din};

  always_comb begin
    hit     = bus.din_vld & ~bus.pat_ld &
              (fill_q == FILL_MAX) & (win == pat_q);
    match_w = hit & ~rst;
  end

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (bus.pat_ld) begin
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.din_vld) begin
      if (hit && (bus.ovl_mode == MODE_NOVL)) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = win[PAT_W-2:0];
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= RST_PAT;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign bus.match = match_w;
  assign bus.busy  = (fill_q != '0);

`ifdef SEQ_DET_CNT_EN
  seq_sat_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.pat_ld),
    .inc (match_w),
    .cnt (bus.match_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed, table-driven bench for seq_det_prog.
// Counter checks run only when SEQ_DET_CNT_EN is defined.
module tb_seq_det_prog;

  localparam int PAT_W = 4;
  localparam int CW    = 2;

  typedef struct {
    bit         rst;
    bit         vld;
    bit         din;
    bit         ovl;
    bit         ld;
    logic [3:0] pat;
    bit         em;
    bit         eb;
    int         ec;
  } vec_t;

  logic clk;
  logic rst;

  int n_chk;
  int n_fail;

  vec_t tbl[$];

`ifdef SEQ_DET_CNT_EN
  seq_det_prog_if #(.PAT_W(PAT_W), .CNT_W(CW)) bus ();
`else
  seq_det_prog_if #(.PAT_W(PAT_W)) bus ();
`endif

  seq_det_prog #(
    .PAT_W   (PAT_W),
    .RST_PAT (4'b1010),
    .CNT_W   (CW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, got, exp);
    end
  endtask

  function automatic vec_t mk(input bit r, input bit v, input bit d,
                              input bit o, input bit l,
                              input logic [3:0] p,
                              input bit em, input bit eb,
                              input int ec = -1);
    vec_t x;
    x.rst = r; x.vld = v; x.din = d; x.ovl = o; x.ld = l;
    x.pat = p; x.em = em; x.eb = eb; x.ec = ec;
    return x;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst          = v.rst;
    bus.din_vld  = v.vld;
    bus.din      = v.din;
    bus.ovl_mode = v.ovl;
    bus.pat_ld   = v.ld;
    bus.pat_in   = v.pat;
    #1;
    chk("match", idx, {31'd0, bus.match}, {31'd0, v.em});
    chk("busy", idx, {31'd0, bus.busy}, {31'd0, v.eb});
`ifdef SEQ_DET_CNT_EN
    if (v.ec >= 0) chk("cnt", idx, {30'd0, bus.match_cnt}, v.ec);
`endif
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst          = 1'b1;
    bus.din      = 1'b0;
    bus.din_vld  = 1'b0;
    bus.ovl_mode = 1'b0;
    bus.pat_ld   = 1'b0;
    bus.pat_in   = 4'b0000;

    // non-overlap 1,0,1,0,1,0 then hold, then reset
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,0));
    tbl.push_back(mk(0,1,0,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'h0,1,1));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,0));
    tbl.push_back(mk(0,1,0,0,0,4'h0,0,1));
    tbl.push_back(mk(0,0,1,0,0,4'h0,0,1));
    tbl.push_back(mk(1,0,0,0,0,4'h0,0,1));
    // overlap 1,0,1,0,1,0
    tbl.push_back(mk(0,1,1,1,0,4'h0,0,0));
    tbl.push_back(mk(0,1,0,1,0,4'h0,0,1));
    tbl.push_back(mk(0,1,1,1,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,1,0,4'h0,1,1));
    tbl.push_back(mk(0,1,1,1,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,1,0,4'h0,1,1));
    tbl.push_back(mk(1,0,0,0,0,4'h0,0,1,2));
    // gaps with garbage data on invalid cycles
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'h0,0,1));
    tbl.push_back(mk(0,0,1,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,1));
    tbl.push_back(mk(0,0,0,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'h0,1,1));
    tbl.push_back(mk(0,0,0,0,0,4'h0,0,0));
    // pat_ld at fill 2 discards the bit, then 1,1,0,1
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,0));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,1,0,1,4'hD,0,1));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,0));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,1,0,0,4'h0,1,1));
    // pat_ld masks a would-be match, restores 1010
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,0));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,1,0,1,4'hA,0,1));
    tbl.push_back(mk(0,0,0,0,0,4'h0,0,0,0));
    // mid-stream reset after 1,0,1 masks match
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,0));
    tbl.push_back(mk(0,1,0,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,1));
    tbl.push_back(mk(1,1,0,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'h0,0,0));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'h0,1,1));
    // overlap then switch to non-overlap mid-stream
    tbl.push_back(mk(0,1,1,1,0,4'h0,0,0));
    tbl.push_back(mk(0,1,0,1,0,4'h0,0,1));
    tbl.push_back(mk(0,1,1,1,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,1,0,4'h0,1,1));
    tbl.push_back(mk(0,1,1,0,0,4'h0,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'h0,1,1));
    tbl.push_back(mk(0,0,0,0,0,4'h0,0,0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 0, {31'd0, bus.busy}, 32'd0);
    chk("rst_match", 0, {31'd0, bus.match}, 32'd0);
`ifdef SEQ_DET_CNT_EN
    chk("rst_cnt", 0, {30'd0, bus.match_cnt}, 32'd0);
`endif

    foreach (tbl[i]) apply(tbl[i], i);

`ifdef SEQ_DET_CNT_EN
    // saturation: overlap, 1,0 x10 gives 9 matches, held at 3
    apply(mk(1,0,0,0,0,4'h0,0,0), 900);
    for (int i = 0; i < 20; i++) begin
      apply(mk(0,1,((i % 2) == 0),1,0,4'h0,
               (i >= 3) && ((i % 2) == 1),i != 0), 1000 + i);
    end
    apply(mk(0,0,0,1,0,4'h0,0,1,3), 1100);
    apply(mk(0,0,0,1,0,4'h0,0,1,3), 1101);
    apply(mk(0,0,0,1,1,4'hA,0,1,3), 1102);
    apply(mk(0,0,0,1,0,4'h0,0,0,0), 1103);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
